mc_control_unit_hs: RTL and testbench
=====================================

# mc_control_unit_hs

Multicycle RV32I control unit with a memory ready handshake, the full conditional-branch set, AUIPC, an explicit halt, and fault detection. It sits between the instruction register and flag outputs of the multicycle datapath and drives every datapath mux and write enable. All memory accesses stall until `mem_ready`. A bounded wait counter converts a hung memory into a fault instead of a deadlock.

## Interface
- `MEM_WAIT_MAX`, 15: maximum stall cycles per memory access before fault; must be ≥1.
- `WAIT_CNT_W`, `$clog2(MEM_WAIT_MAX+1)`: wait counter width.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7, `func3` in 3, `func7` in 7: instruction fields from IR.
- `Zero`, `lt`, `ltu` in 1 each: ALU flags. `lt` is the signed less-than flag, `ltu` the unsigned one.
- `mem_ready` in 1: memory completes the current access this cycle.
- `MemReq` out 1: a memory access is pending.
- `AdrSrc`, `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` out 1 each.
- `ResultSrc`, `ALUSrcA`, `ALUSrcB` out 2 each.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 100 passB, 101 slt, 110 sltu, 111 xor.
- `done` out 1: halted normally.
- `error` out 1: halted on fault.
- `ErrCode` out 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- States: FETCH, DECODE, BRANCH, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JALR_ADR, JAL_ADR, JUMP, LINKWB, LUI, AUIPC, HALT, FAULT.
- Mux encodings:
  - ALUSrcA: 00 PC, 01 OldPC, 10 rs1.
  - ALUSrcB: 00 rs2, 01 imm, 10 const 4.
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
- FETCH:
  - Drives `MemReq=1`, `AdrSrc=0`, `ALUSrcB=10`, `ResultSrc=10`.
  - `IRWrite` and `PCWrite` are each asserted only in a cycle where `mem_ready=1`; the FSM then moves to DECODE.
- DECODE:
  - Drives `ALUSrcA=01`, `ALUSrcB=01`, `ImmSrc=010` to precompute the branch target.
  - Dispatches by opcode:
    - lw → MEMADR; sw → MEMADR.
    - R → EXECR; I → EXECI; B → BRANCH.
    - jalr → JALR_ADR; jal → JAL_ADR.
    - lui → LUI; auipc (0010111) → AUIPC.
    - op=0000000 → HALT.
    - Any other opcode → FAULT with code 01.
- BRANCH:
  - Drives `ALUSrcA=10`, `ALUSrcB=00`, ALU sub.
  - Asserts `PCWrite` when the branch is taken:
    - beq: Zero. bne: !Zero.
    - blt: lt. bge: !lt.
    - bltu: ltu. bgeu: !ltu.
    - func3 010 or 011: not taken, no fault.
  - Next state is FETCH.
- MEMADR:
  - Drives `ALUSrcA=10`, `ALUSrcB=01`, ALU add.
  - ImmSrc is 000 for loads and 001 for stores.
  - Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: drives `MemReq=1`, `AdrSrc=1`; holds until `mem_ready`, then moves to MEMWB.
- MEMWB: drives `ResultSrc=01`, `RegWrite=1`, then FETCH.
- MEMWRITE: drives `MemReq=1`, `AdrSrc=1`, `MemWrite=1`; holds until `mem_ready`, then FETCH.
- EXECR / EXECI:
  - EXECR drives `ALUSrcA=10`, `ALUSrcB=00`; EXECI drives `ALUSrcA=10`, `ALUSrcB=01`.
  - ALU operation comes from func3 (and func7 for R-type):
    - add, or sub when R-type with func7=0100000.
    - 111 and, 110 or, 100 xor, 010 slt, 011 sltu.
  - Next state is ALUWB.
- ALUWB: drives `RegWrite=1`, `ResultSrc=00`, then FETCH.
- JALR_ADR: rs1+immI. JAL_ADR: OldPC+immJ.
- JUMP: drives `PCWrite=1`, `ResultSrc=00`, and sets the ALU to OldPC+4. Next state is LINKWB.
- LINKWB: drives `RegWrite=1`, then FETCH.
- LUI: drives `ImmSrc=100`, `ALUSrcB=01`, passB, then ALUWB.
- AUIPC: drives `ImmSrc=100`, `ALUSrcA=01`, `ALUSrcB=01`, add, then ALUWB.
- HALT and FAULT are absorbing states; only `rst` leaves them.
  - HALT drives `done=1`.
  - FAULT drives `error=1` and holds `ErrCode` registered from fault entry.
- Wait counter:
  - Clears on entry to any memory state and increments each cycle that `MemReq=1` and `mem_ready=0`.
  - When the counter equals `MEM_WAIT_MAX` and `mem_ready=0`, the next state is FAULT with code 10. `mem_ready` in that same cycle wins and completes the access normally.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - State goes to FETCH and the wait counter and ErrCode clear.
  - All outputs are 0 except FETCH's combinational outputs.
  - Reset takes priority over every transition, including mid-stall; a pending access is abandoned.
- Outputs are Moore functions of state, with two exceptions:
  - The BRANCH `PCWrite`.
  - The `mem_ready`-gated writes in FETCH, MEMREAD, and MEMWRITE.
- Zero-wait cycle counts: lw 5; sw, R, I, lui, auipc 4; branch 3; jal and jalr 5.
- Each stall cycle adds 1 to the count. The maximum stall per access is `MEM_WAIT_MAX` cycles; FAULT is entered on the following edge.

## Configuration
- `MC_CTRL_PERF_EN`: when defined, adds two outputs:
  - `InstRet` out 32: counts transitions into FETCH from any non-reset state, i.e. completed instructions.
  - `CycleCnt` out 32: counts every cycle not in HALT or FAULT.
  - Both counters clear on `rst` and wrap modulo 2^32.
- Without the macro, neither port nor either counter exists.

## Structure
- Package `mc_ctrl_pkg` holds:
  - Opcode constants.
  - The state enum.
  - ALUControl, ImmSrc, and ErrCode constants.
  - Mux-select constants.
- One sub-module, `mc_alu_decoder`, is combinational. It maps the ALU operation class (add, sub, func, passB) plus func3, func7, and op to ALUControl.

## Test plan
- `add` with `mem_ready` held at 1 → FETCH, DECODE, EXECR, ALUWB; `RegWrite=1` in cycle 4; `ALUControl=000`.
- lw with `mem_ready` low for 3 cycles in MEMREAD → `MemReq=1`, `AdrSrc=1` held; total 8 cycles; `RegWrite` only in MEMWB.
- bgeu with `ltu=0` → `PCWrite=1` in BRANCH; the same instruction with `ltu=1` → `PCWrite=0`; both take 3 cycles.
- `MEM_WAIT_MAX=4`, `mem_ready` never asserted in FETCH → FAULT after 4 stall cycles; `error=1`, `ErrCode=10`; stays in FAULT until `rst`.
- Opcode 1111111 → `error=1`, `ErrCode=01`. Opcode 0000000 → `done=1`, `error=0`. Asserting `rst` in either → FETCH on the next edge.
- With `MC_CTRL_PERF_EN` defined: lw, sw, halt → `InstRet=2`, `CycleCnt=11` at halt.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control unit: opcodes, FSM state codes,
// datapath mux selects, ALU/immediate encodings and fault codes.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    localparam logic [4:0] S_FETCH    = 5'd0;
    localparam logic [4:0] S_DECODE   = 5'd1;
    localparam logic [4:0] S_BRANCH   = 5'd2;
    localparam logic [4:0] S_MEMADR   = 5'd3;
    localparam logic [4:0] S_MEMREAD  = 5'd4;
    localparam logic [4:0] S_MEMWB    = 5'd5;
    localparam logic [4:0] S_MEMWRITE = 5'd6;
    localparam logic [4:0] S_EXECR    = 5'd7;
    localparam logic [4:0] S_EXECI    = 5'd8;
    localparam logic [4:0] S_ALUWB    = 5'd9;
    localparam logic [4:0] S_JALR_ADR = 5'd10;
    localparam logic [4:0] S_JAL_ADR  = 5'd11;
    localparam logic [4:0] S_JUMP     = 5'd12;
    localparam logic [4:0] S_LINKWB   = 5'd13;
    localparam logic [4:0] S_LUI      = 5'd14;
    localparam logic [4:0] S_AUIPC    = 5'd15;
    localparam logic [4:0] S_HALT     = 5'd16;
    localparam logic [4:0] S_FAULT    = 5'd17;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SLTU  = 3'b110;
    localparam logic [2:0] ALU_XOR   = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_MEM_TO  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef enum logic [1:0] {
        ALUCLS_ADD,
        ALUCLS_SUB,
        ALUCLS_FUNC,
        ALUCLS_PASSB
    } alu_cls_t;

    // func3 010/011 are not branches in RV32I; they fall through as not-taken.
    function automatic logic branch_taken(input logic [2:0] func3, input logic zero,
                                          input logic lt, input logic ltu);
        case (func3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an ALUControl code.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   alu_cls_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] func7_i,
    input  logic [6:0] op_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_cls_i)
            ALUCLS_ADD:   alu_ctrl_o = ALU_ADD;
            ALUCLS_SUB:   alu_ctrl_o = ALU_SUB;
            ALUCLS_PASSB: alu_ctrl_o = ALU_PASSB;
            ALUCLS_FUNC: begin
                case (func3_i)
                    // Only R-type reads func7; addi with a stray bit 30 stays an add.
                    3'b000:  alu_ctrl_o = (op_i == OP_RTYPE && func7_i == 7'b0100000)
                                          ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit_hs.sv
// Multicycle RV32I control FSM with memory ready handshake, bounded stall timeout and halt/fault.
// Optional MC_CTRL_PERF_EN adds retired-instruction and active-cycle counters.
//
// state    | meaning
// FETCH    | read instruction, PC+4 on mem_ready
// DECODE   | dispatch on opcode, precompute branch target
// BRANCH   | compare, PCWrite when taken
// MEMADR   | rs1+imm effective address
// MEMREAD  | load access, wait for mem_ready
// MEMWB    | write load data to rd
// MEMWRITE | store access, wait for mem_ready
// EXECR/I  | ALU op on rs2 / imm
// ALUWB    | write ALUOut to rd
// JALR/JAL | jump target into ALUOut
// JUMP     | PC <- target, ALU computes link
// LINKWB   | write link to rd
// LUI/AUIPC| upper immediate (+OldPC)
// HALT     | done, absorbing
// FAULT    | error + ErrCode, absorbing
module mc_control_unit_hs
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = $clog2(MEM_WAIT_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       done,
    output logic       error,
    output logic [1:0] ErrCode
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] InstRet,
    output logic [31:0] CycleCnt
`endif
);

    logic [4:0]            state_q, state_d;
    logic [1:0]            err_q, err_d;
    logic [WAIT_CNT_W-1:0] wait_q;
    logic                  timeout;
    alu_cls_t              alu_cls;

    assign timeout = (wait_q == WAIT_CNT_W'(MEM_WAIT_MAX));

    mc_alu_decoder u_alu_dec (
        .alu_cls_i (alu_cls),
        .func3_i   (func3),
        .func7_i   (func7),
        .op_i      (op),
        .alu_ctrl_o(ALUControl)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        MemReq    = 1'b0;
        AdrSrc    = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        done      = 1'b0;
        error     = 1'b0;
        ErrCode   = ERR_NONE;
        alu_cls   = ALUCLS_ADD;
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                    err_d   = ERR_MEM_TO;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_JAL:            state_d = S_JAL_ADR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_HALT:           state_d = S_HALT;
                    default: begin
                        state_d = S_FAULT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                alu_cls = ALUCLS_SUB;
                PCWrite = branch_taken(func3, Zero, lt, ltu);
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = (state_q == S_MEMWRITE);
                if (mem_ready) begin
                    state_d = (state_q == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FAULT;
                    err_d   = ERR_MEM_TO;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                alu_cls = ALUCLS_FUNC;
                state_d = S_ALUWB;
            end
            S_ALUWB, S_LINKWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JUMP;
            end
            S_JAL_ADR: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_J;
                state_d = S_JUMP;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                state_d = S_LINKWB;
            end
            S_LUI: begin
                ImmSrc  = IMM_U;
                ALUSrcB = SRCB_IMM;
                alu_cls = ALUCLS_PASSB;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ImmSrc  = IMM_U;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_HALT:  done = 1'b1;
            S_FAULT: begin
                error   = 1'b1;
                ErrCode = err_q;
            end
            default: begin
                state_d = S_FAULT;
                err_d   = ERR_ILLEGAL;
            end
        endcase
    end

    // The wait counter restarts on every state change, so each access gets its own budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (MemReq && !mem_ready) begin
                wait_q <= wait_q + WAIT_CNT_W'(1);
            end
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] inst_ret_q;
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ret_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (state_d == S_FETCH && state_q != S_FETCH) begin
                inst_ret_q <= inst_ret_q + 32'd1;
            end
            if (state_q != S_HALT && state_q != S_FAULT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
        end
    end

    assign InstRet  = inst_ret_q;
    assign CycleCnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Directed cycle-by-cycle bench for mc_control_unit_hs; every control output is packed
// into one word per cycle and compared with hand-derived expected values.
module tb_mc_control_unit_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero, lt, ltu, mem_ready;
    logic       MemReq, AdrSrc, PCWrite, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic       done, error;
    logic [1:0] ErrCode;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] InstRet, CycleCnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_control_unit_hs #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .Zero(Zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .MemReq(MemReq), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .done(done), .error(error), .ErrCode(ErrCode)
`ifdef MC_CTRL_PERF_EN
        , .InstRet(InstRet), .CycleCnt(CycleCnt)
`endif
    );

    // {MemReq,AdrSrc,PCWrite,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,done,error,ErrCode}
    function automatic logic [21:0] sg(input logic mrq, adr, pcw, irw, mw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] imm, alu,
                                       input logic dn, er, input logic [1:0] ec);
        return {mrq, adr, pcw, irw, mw, rw, rs, sa, sb, imm, alu, dn, er, ec};
    endfunction

    logic [21:0] obs;
    assign obs = {MemReq, AdrSrc, PCWrite, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, done, error, ErrCode};

    logic [21:0] E_FR, E_FS, E_DEC, E_XR_ADD, E_XR_SUB, E_XR_XOR, E_XI_ADD, E_XI_SLT;
    logic [21:0] E_WB, E_MA_LW, E_MA_SW, E_MR, E_MWB, E_MW, E_BR_T, E_BR_N;
    logic [21:0] E_JAL, E_JALR, E_JMP, E_LUI, E_AUI, E_HALT, E_FLT1, E_FLT2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic mr, input logic [21:0] exp);
        mem_ready = mr;
        #1;
        check(tag, {10'b0, obs}, {10'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        E_FR     = sg(1,0,1,1,0,0, 2,0,2, 0,0, 0,0,0);
        E_FS     = sg(1,0,0,0,0,0, 2,0,2, 0,0, 0,0,0);
        E_DEC    = sg(0,0,0,0,0,0, 0,1,1, 2,0, 0,0,0);
        E_XR_ADD = sg(0,0,0,0,0,0, 0,2,0, 0,0, 0,0,0);
        E_XR_SUB = sg(0,0,0,0,0,0, 0,2,0, 0,1, 0,0,0);
        E_XR_XOR = sg(0,0,0,0,0,0, 0,2,0, 0,7, 0,0,0);
        E_XI_ADD = sg(0,0,0,0,0,0, 0,2,1, 0,0, 0,0,0);
        E_XI_SLT = sg(0,0,0,0,0,0, 0,2,1, 0,5, 0,0,0);
        E_WB     = sg(0,0,0,0,0,1, 0,0,0, 0,0, 0,0,0);
        E_MA_LW  = sg(0,0,0,0,0,0, 0,2,1, 0,0, 0,0,0);
        E_MA_SW  = sg(0,0,0,0,0,0, 0,2,1, 1,0, 0,0,0);
        E_MR     = sg(1,1,0,0,0,0, 0,0,0, 0,0, 0,0,0);
        E_MWB    = sg(0,0,0,0,0,1, 1,0,0, 0,0, 0,0,0);
        E_MW     = sg(1,1,0,0,1,0, 0,0,0, 0,0, 0,0,0);
        E_BR_T   = sg(0,0,1,0,0,0, 0,2,0, 0,1, 0,0,0);
        E_BR_N   = sg(0,0,0,0,0,0, 0,2,0, 0,1, 0,0,0);
        E_JAL    = sg(0,0,0,0,0,0, 0,1,1, 3,0, 0,0,0);
        E_JALR   = sg(0,0,0,0,0,0, 0,2,1, 0,0, 0,0,0);
        E_JMP    = sg(0,0,1,0,0,0, 0,1,2, 0,0, 0,0,0);
        E_LUI    = sg(0,0,0,0,0,0, 0,0,1, 4,4, 0,0,0);
        E_AUI    = sg(0,0,0,0,0,0, 0,1,1, 4,0, 0,0,0);
        E_HALT   = sg(0,0,0,0,0,0, 0,0,0, 0,0, 1,0,0);
        E_FLT1   = sg(0,0,0,0,0,0, 0,0,0, 0,0, 0,1,1);
        E_FLT2   = sg(0,0,0,0,0,0, 0,0,0, 0,0, 0,1,2);

        rst = 1'b1; mem_ready = 1'b0; Zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        ins(7'b0110011, 3'b000, 7'b0000000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset_fetch", 0, E_FS);

        // R/I-type ALU decoding
        cyc("add_f", 1, E_FR); cyc("add_d", 1, E_DEC); cyc("add_x", 1, E_XR_ADD); cyc("add_wb", 1, E_WB);
        ins(7'b0110011, 3'b000, 7'b0100000);
        cyc("sub_f", 1, E_FR); cyc("sub_d", 1, E_DEC); cyc("sub_x", 1, E_XR_SUB); cyc("sub_wb", 1, E_WB);
        ins(7'b0110011, 3'b100, 7'b0100000);
        cyc("xor_f", 1, E_FR); cyc("xor_d", 1, E_DEC); cyc("xor_x", 1, E_XR_XOR); cyc("xor_wb", 1, E_WB);
        ins(7'b0010011, 3'b000, 7'b0100000);
        cyc("addi_f", 1, E_FR); cyc("addi_d", 1, E_DEC); cyc("addi_x", 1, E_XI_ADD); cyc("addi_wb", 1, E_WB);
        ins(7'b0010011, 3'b010, 7'b0000000);
        cyc("slti_f", 1, E_FR); cyc("slti_d", 1, E_DEC); cyc("slti_x", 1, E_XI_SLT); cyc("slti_wb", 1, E_WB);

        // lw with three stall cycles: 8 cycles total
        ins(7'b0000011, 3'b010, 7'b0000000);
        cyc("lw_f", 1, E_FR); cyc("lw_d", 1, E_DEC); cyc("lw_ma", 1, E_MA_LW);
        for (int i = 0; i < 3; i++) cyc("lw_stall", 0, E_MR);
        cyc("lw_mr", 1, E_MR); cyc("lw_wb", 1, E_MWB);
        ins(7'b0100011, 3'b010, 7'b0000000);
        cyc("sw_f", 1, E_FR); cyc("sw_d", 1, E_DEC); cyc("sw_ma", 1, E_MA_SW); cyc("sw_mw", 1, E_MW);

        // branches
        ins(7'b1100011, 3'b111, 7'b0000000); ltu = 1'b0;
        cyc("bgeu_t_f", 1, E_FR); cyc("bgeu_t_d", 1, E_DEC); cyc("bgeu_t_br", 1, E_BR_T);
        ltu = 1'b1;
        cyc("bgeu_n_f", 1, E_FR); cyc("bgeu_n_d", 1, E_DEC); cyc("bgeu_n_br", 1, E_BR_N);
        ins(7'b1100011, 3'b001, 7'b0000000); Zero = 1'b0;
        cyc("bne_f", 1, E_FR); cyc("bne_d", 1, E_DEC); cyc("bne_br", 1, E_BR_T);
        ins(7'b1100011, 3'b100, 7'b0000000); lt = 1'b1;
        cyc("blt_f", 1, E_FR); cyc("blt_d", 1, E_DEC); cyc("blt_br", 1, E_BR_T);
        ins(7'b1100011, 3'b010, 7'b0000000); Zero = 1'b1; lt = 1'b1; ltu = 1'b1;
        cyc("b010_f", 1, E_FR); cyc("b010_d", 1, E_DEC); cyc("b010_br", 1, E_BR_N);

        // jumps and upper immediates
        ins(7'b1101111, 3'b000, 7'b0000000);
        cyc("jal_f", 1, E_FR); cyc("jal_d", 1, E_DEC); cyc("jal_a", 1, E_JAL);
        cyc("jal_j", 1, E_JMP); cyc("jal_l", 1, E_WB);
        ins(7'b1100111, 3'b000, 7'b0000000);
        cyc("jalr_f", 1, E_FR); cyc("jalr_d", 1, E_DEC); cyc("jalr_a", 1, E_JALR);
        cyc("jalr_j", 1, E_JMP); cyc("jalr_l", 1, E_WB);
        ins(7'b0110111, 3'b000, 7'b0000000);
        cyc("lui_fs", 0, E_FS); cyc("lui_fs", 0, E_FS); cyc("lui_f", 1, E_FR);
        cyc("lui_d", 1, E_DEC); cyc("lui_x", 1, E_LUI); cyc("lui_wb", 1, E_WB);
        ins(7'b0010111, 3'b000, 7'b0000000);
        cyc("aui_f", 1, E_FR); cyc("aui_d", 1, E_DEC); cyc("aui_x", 1, E_AUI); cyc("aui_wb", 1, E_WB);

        // ready arriving exactly at the wait limit still completes
        for (int i = 0; i < 4; i++) cyc("edge_fs", 0, E_FS);
        cyc("edge_f", 1, E_FR); cyc("edge_d", 1, E_DEC); cyc("edge_x", 1, E_AUI); cyc("edge_wb", 1, E_WB);

        // reset mid-stall restarts the wait budget
        for (int i = 0; i < 3; i++) cyc("midrst_fs", 0, E_FS);
        do_reset();
        for (int i = 0; i < 4; i++) cyc("postrst_fs", 0, E_FS);
        cyc("postrst_f", 1, E_FR); cyc("postrst_d", 1, E_DEC); cyc("postrst_x", 1, E_AUI); cyc("postrst_wb", 1, E_WB);

        // memory timeout in FETCH
        for (int i = 0; i < 5; i++) cyc("to_fs", 0, E_FS);
        for (int i = 0; i < 3; i++) cyc("to_fault", 1, E_FLT2);
        do_reset();
        cyc("to_rst", 0, E_FS);

        // illegal opcode
        ins(7'b1111111, 3'b000, 7'b0000000);
        cyc("ill_f", 1, E_FR); cyc("ill_d", 1, E_DEC);
        for (int i = 0; i < 3; i++) cyc("ill_fault", 1, E_FLT1);
        do_reset();
        cyc("ill_rst", 0, E_FS);

        // halt
        ins(7'b0000000, 3'b000, 7'b0000000);
        cyc("halt_f", 1, E_FR); cyc("halt_d", 1, E_DEC);
        for (int i = 0; i < 3; i++) cyc("halt", 1, E_HALT);
        do_reset();
        cyc("halt_rst", 0, E_FS);

`ifdef MC_CTRL_PERF_EN
        do_reset();
        ins(7'b0000011, 3'b010, 7'b0000000);
        cyc("p_lw_f", 1, E_FR); cyc("p_lw_d", 1, E_DEC); cyc("p_lw_ma", 1, E_MA_LW);
        cyc("p_lw_mr", 1, E_MR); cyc("p_lw_wb", 1, E_MWB);
        ins(7'b0100011, 3'b010, 7'b0000000);
        cyc("p_sw_f", 1, E_FR); cyc("p_sw_d", 1, E_DEC); cyc("p_sw_ma", 1, E_MA_SW); cyc("p_sw_mw", 1, E_MW);
        ins(7'b0000000, 3'b000, 7'b0000000);
        cyc("p_halt_f", 1, E_FR); cyc("p_halt_d", 1, E_DEC);
        check("inst_ret", InstRet, 32'd2);
        check("cycle_cnt", CycleCnt, 32'd11);
        cyc("p_halt", 1, E_HALT);
        check("cycle_cnt_frozen", CycleCnt, 32'd11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
